// File: rtl/bist_pattern_misr.sv
// ============================================================================
// Module   : bist_pattern_misr
// Brief    : Exhaustive 3-bit pattern generator and 3-bit MISR compactor with
//            golden-signature compare for the A/B/C -> X/Y/Z example CUT.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bist_pattern_misr #(
   parameter int         N_PAT    = 8,
   parameter int         WAIT_CYC = 1,
   parameter logic [2:0] SEED     = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] golden_sig,
   output logic       cut_a,
   output logic       cut_b,
   output logic       cut_c,
   input  logic       cut_x,
   input  logic       cut_y,
   input  logic       cut_z,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] signature
);

   localparam int                  c_WCNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(WAIT_CYC - 1);
   localparam logic [2:0]          c_LAST_IDX  = 3'(N_PAT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_APPLY   = 3'd1,
      S_CAPTURE = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_idx;
   logic [2:0]          r_pat;
   logic [c_WCNT_W-1:0] r_wcnt;
   logic [2:0]          r_sig;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic                w_last_wait;
   logic                w_last_pat;
   logic [2:0]          w_misr_next;

   assign w_last_wait = (r_wcnt == c_WAIT_LAST);
   assign w_last_pat  = (r_idx == c_LAST_IDX);
   // Shift with feedback x^3 + x^2 + 1 folded into bit 0, then fold in XYZ
   assign w_misr_next = {r_sig[1], r_sig[0], r_sig[2] ^ r_sig[1]} ^ {cut_x, cut_y, cut_z};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_APPLY;
         S_APPLY:        if (w_last_wait) w_next = S_CAPTURE;
         S_CAPTURE:      w_next = w_last_pat ? S_COMPARE : S_APPLY;
         S_COMPARE:      w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_pat  <= '0;
         r_wcnt <= '0;
         r_sig  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_sig  <= SEED;
                  r_idx  <= '0;
                  r_pat  <= '0;
                  r_wcnt <= '0;
                  r_busy <= 1'b1;
                  r_done <= 1'b0;
                  r_pass <= 1'b0;
               end
            end
            S_APPLY: begin
               r_wcnt <= w_last_wait ? '0 : r_wcnt + c_WCNT_W'(1);
            end
            S_CAPTURE: begin
               r_sig <= w_misr_next;
               if (!w_last_pat) begin
                  r_idx <= r_idx + 3'd1;
                  r_pat <= r_idx + 3'd1;
               end
            end
            S_COMPARE: begin
               r_pass <= (r_sig == golden_sig);
               r_done <= 1'b1;
               r_busy <= 1'b0;
               r_pat  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign {cut_a, cut_b, cut_c} = r_pat;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = r_sig;

endmodule

`default_nettype wire

// File: tb/tb_bist_pattern_misr.sv
// ============================================================================
// Module   : tb_bist_pattern_misr
// Brief    : Self-checking bench for bist_pattern_misr (default and short-run
//            parameterisations sharing one clock).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bist_pattern_misr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] golden;
   bit         faulty;
   int         sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Example CUT behaviour, fault-free and with node s stuck-at-1
   function automatic logic [2:0] cut_resp(input logic [2:0] k, input bit f);
      if (k < 3'd6) return 3'b111;
      if (!f)       return 3'b001;
      return (k == 3'd6) ? 3'b011 : 3'b010;
   endfunction

   function automatic logic [2:0] sig_after(input int n, input bit f);
      logic [2:0] s;
      logic [2:0] r;
      s = 3'b000;
      for (int k = 0; k < n; k++) begin
         r = cut_resp(3'(k), f);
         s = {s[1], s[0], s[2] ^ s[1]} ^ r;
      end
      return s;
   endfunction

   logic       a0, b0, c0, x0, y0, z0, busy0, done0, pass0, start0;
   logic       a1, b1, c1, x1, y1, z1, busy1, done1, pass1, start1;
   logic [2:0] sig0, sig1;

   assign start0 = start && (sel == 0);
   assign start1 = start && (sel == 1);
   assign {x0, y0, z0} = cut_resp({a0, b0, c0}, faulty);
   assign {x1, y1, z1} = cut_resp({a1, b1, c1}, faulty);

   bist_pattern_misr u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .golden_sig(golden),
      .cut_a(a0), .cut_b(b0), .cut_c(c0), .cut_x(x0), .cut_y(y0), .cut_z(z0),
      .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));

   bist_pattern_misr #(.N_PAT(2), .WAIT_CYC(3), .SEED(3'b000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .golden_sig(golden),
      .cut_a(a1), .cut_b(b1), .cut_c(c1), .cut_x(x1), .cut_y(y1), .cut_z(z1),
      .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

   logic       m_busy, m_done, m_pass;
   logic [2:0] m_sig, m_pat;
   always_comb begin
      m_busy = (sel == 1) ? busy1 : busy0;
      m_done = (sel == 1) ? done1 : done0;
      m_pass = (sel == 1) ? pass1 : pass0;
      m_sig  = (sel == 1) ? sig1  : sig0;
      m_pat  = (sel == 1) ? {a1, b1, c1} : {a0, b0, c0};
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int         sel;
      bit         faulty;
      logic [2:0] golden;
      int         inject;
      logic [2:0] exp_sig;
      bit         exp_pass;
      int         exp_lat;
   } vec_t;

   task automatic run(input int s, input bit f, input logic [2:0] g, input int inject_at,
                      input logic [2:0] exp_sig, input bit exp_pass, input int exp_lat);
      int w, n, cyc, k;
      logic [2:0] hold_sig;
      w = (s == 1) ? 3 : 1;
      n = (s == 1) ? 2 : 8;
      sel = s; faulty = f; golden = g;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_after_start", m_busy, 1);
      chk("done_after_start", m_done, 0);
      chk("first_pattern", m_pat, 0);
      cyc = 0; k = 0;
      while (!m_done && cyc < 200) begin
         if (inject_at != 0 && cyc == inject_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (k < n && cyc == (k + 1) * (w + 1)) begin
            chk("misr_step", m_sig, sig_after(k + 1, f));
            k++;
         end
      end
      chk("latency", cyc, exp_lat);
      chk("final_sig", m_sig, exp_sig);
      chk("pass", m_pass, exp_pass);
      chk("busy_in_done", m_busy, 0);
      chk("pattern_in_done", m_pat, 0);
      hold_sig = m_sig;
      repeat (3) @(negedge clk);
      chk("done_held", m_done, 1);
      chk("sig_held", m_sig, hold_sig);
   endtask

   vec_t tbl[6];

   initial begin
      int seen, cyc, rs, rf, rg, n;
      rst_n = 1'b0; start = 1'b0; sel = 0; golden = 3'b000; faulty = 1'b0;

      tbl[0] = '{0, 1'b0, 3'b101, 0, 3'b101, 1'b1, 17};
      tbl[1] = '{0, 1'b1, 3'b101, 0, 3'b011, 1'b0, 17};
      tbl[2] = '{0, 1'b1, 3'b011, 0, 3'b011, 1'b1, 17};
      tbl[3] = '{0, 1'b0, 3'b000, 5, 3'b101, 1'b0, 17};
      tbl[4] = '{1, 1'b0, 3'b001, 0, 3'b001, 1'b1, 9};
      tbl[5] = '{1, 1'b1, 3'b000, 0, 3'b001, 1'b0, 9};

      repeat (2) @(negedge clk);
      chk("rst_busy", {busy0, busy1}, 0);
      chk("rst_done", {done0, done1}, 0);
      chk("rst_pass", {pass0, pass1}, 0);
      chk("rst_sig", {sig0, sig1}, 0);
      chk("rst_cut", {a0, b0, c0, a1, b1, c1}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run(tbl[i].sel, tbl[i].faulty, tbl[i].golden, tbl[i].inject,
             tbl[i].exp_sig, tbl[i].exp_pass, tbl[i].exp_lat);

      // Asynchronous reset while pattern 3 is being applied
      sel = 0; faulty = 1'b0; golden = 3'b101;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_pattern3", {a0, b0, c0}, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_busy", busy0, 0);
      chk("async_done", done0, 0);
      chk("async_pass", pass0, 0);
      chk("async_sig", sig0, 0);
      chk("async_cut", {a0, b0, c0}, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (cyc = 0; cyc < 25; cyc++) begin
         @(negedge clk);
         if (done0 || busy0) seen++;
      end
      chk("no_resume_after_reset", seen, 0);

      // Randomised runs against the reference model
      for (int i = 0; i < 8; i++) begin
         rs = int'($urandom_range(0, 1));
         rf = int'($urandom_range(0, 1));
         rg = int'($urandom_range(0, 7));
         n  = (rs == 1) ? 2 : 8;
         run(rs, rf[0], 3'(rg), (rs == 0) ? int'($urandom_range(0, 12)) : 0,
             sig_after(n, rf[0]), sig_after(n, rf[0]) == 3'(rg),
             n * (((rs == 1) ? 3 : 1) + 1) + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
